// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter with selectable bit order and a one-word output holding register.
// Optional even-parity trailer bit per word when SERIAL_TO_PARALLEL_PARITY_EN is defined.
module serial_to_parallel #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic             serial_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    PARITY  = 2'd1,
`endif
    STALL   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             oval_q, oval_d;

  logic             accept;
  logic             dir_eff;
  logic [WIDTH-1:0] sr_shift;
  logic             done;
  logic [WIDTH-1:0] done_word;
  logic             ld;
  logic [WIDTH-1:0] ld_word;

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic done_par, ld_par;
`endif

  assign serial_ready = enable && (state_q == COLLECT
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                                   || state_q == PARITY
`endif
                                  );
  assign accept   = serial_ready && serial_valid;
  // The first bit of a word uses the live dir; later bits use the latched copy.
  assign dir_eff  = (cnt_q == '0) ? dir : dir_q;
  assign sr_shift = dir_eff ? {sr_q[WIDTH-2:0], serial_in} : {serial_in, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pout_d    = pout_q;
    oval_d    = oval_q;
    done      = 1'b0;
    done_word = sr_q;
    ld        = 1'b0;
    ld_word   = sr_q;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    par_d     = par_q;
    perr_d    = perr_q;
    done_par  = par_q;
    ld_par    = par_q;
`endif

    case (state_q)
      COLLECT: begin
        if (accept) begin
          sr_d = sr_shift;
          if (cnt_q == '0) dir_d = dir;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            state_d = PARITY;
`else
            done      = 1'b1;
            done_word = sr_shift;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      PARITY: begin
        if (accept) begin
          done      = 1'b1;
          done_word = sr_q;
          done_par  = serial_in;
          par_d     = serial_in;
        end
      end
`endif
      STALL: begin
        if (out_ready) begin
          ld      = 1'b1;
          ld_word = sr_q;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (done) begin
      if (!oval_q || out_ready) begin
        ld      = 1'b1;
        ld_word = done_word;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        ld_par  = done_par;
`endif
        state_d = COLLECT;
      end else begin
        state_d = STALL;
      end
    end

    if (ld) begin
      pout_d = ld_word;
      oval_d = 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      perr_d = (^ld_word) ^ ld_par;
`endif
    end else if (oval_q && out_ready) begin
      oval_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pout_q  <= '0;
      oval_q  <= 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pout_q  <= pout_d;
      oval_q  <= oval_d;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign parallel_out = pout_q;
  assign out_valid    = oval_q;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized and directed bench for serial_to_parallel; words are rebuilt by bit position
// in a queue-based reference and compared when the consumer takes them.
module tb_serial_to_parallel;
  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset, enable, dir, serial_in, serial_valid, out_ready;
  logic             serial_ready, out_valid, parity_err;
  logic [WIDTH-1:0] parallel_out;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_w[$];
  logic             exp_p[$];
  logic [WIDTH-1:0] m_word;
  logic             m_dir;
  int               m_cnt;

  serial_to_parallel #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dir(dir),
    .serial_in(serial_in), .serial_valid(serial_valid), .serial_ready(serial_ready),
    .parallel_out(parallel_out), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    exp_w.delete();
    exp_p.delete();
    m_cnt  = 0;
    m_word = '0;
    m_dir  = 1'b0;
  endtask

  // Places each accepted bit at its final position in the word.
  task automatic model_accept(input logic b, input logic d);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    if (m_cnt == WIDTH) begin
      exp_w.push_back(m_word);
      exp_p.push_back((^m_word) ^ b);
      m_cnt = 0;
      return;
    end
`endif
    if (m_cnt == 0) m_dir = d;
    if (m_dir) m_word[WIDTH-1-m_cnt] = b;
    else       m_word[m_cnt] = b;
    m_cnt++;
`ifndef SERIAL_TO_PARALLEL_PARITY_EN
    if (m_cnt == WIDTH) begin
      exp_w.push_back(m_word);
      exp_p.push_back(1'b0);
      m_cnt = 0;
    end
`endif
  endtask

  // One clock cycle: drive at negedge, settle, score handshakes, return at next negedge.
  task automatic step(input logic en, input logic v, input logic b, input logic d, input logic rdy);
    logic [WIDTH-1:0] ew;
    logic             ep;
    enable = en; serial_valid = v; serial_in = b; dir = d; out_ready = rdy;
    #1;
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_w.size() == 0) begin
        bad++;
        $display("FAIL consume_spurious: got word %b, expected none pending", parallel_out);
      end else begin
        ew = exp_w.pop_front();
        ep = exp_p.pop_front();
        if (parallel_out !== ew || parity_err !== ep) begin
          bad++;
          $display("FAIL consume_word: got %b/perr %b, expected %b/perr %b", parallel_out, parity_err, ew, ep);
        end
      end
    end
    if (!reset && enable && serial_valid && serial_ready) model_accept(b, d);
    @(posedge clock);
    @(negedge clock);
  endtask

  // seq/dseq: element WIDTH-1 is sent first. flip inverts the even-parity trailer.
  task automatic send_word(input logic [WIDTH-1:0] seq, input logic [WIDTH-1:0] dseq,
                           input logic rdy, input logic flip);
    for (int i = WIDTH-1; i >= 0; i--) step(1'b1, 1'b1, seq[i], dseq[i], rdy);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    step(1'b1, 1'b1, (^seq) ^ flip, dseq[0], rdy);
`else
    if (flip) step(1'b1, 1'b0, 1'b0, 1'b0, rdy);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (parallel_out !== '0 || out_valid !== 1'b0 || parity_err !== 1'b0 || serial_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got pout=%b ov=%b perr=%b rdy=%b, expected 0000 0 0 1",
               parallel_out, out_valid, parity_err, serial_ready);
    end
  endtask

  task automatic test_msb_first();
    send_word(4'b1011, 4'b1111, 1'b1, 1'b0);
    total++;
    if (parallel_out !== 4'b1011 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL msb_first: got %b ov=%b, expected 1011 ov=1", parallel_out, out_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lsb_first();
    send_word(4'b1010, 4'b0000, 1'b1, 1'b0);
    total++;
    if (parallel_out !== 4'b0101 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL lsb_first: got %b ov=%b, expected 0101 ov=1", parallel_out, out_valid);
    end
    send_word(4'b1010, 4'b0111, 1'b1, 1'b0);
    total++;
    if (parallel_out !== 4'b0101) begin
      bad++;
      $display("FAIL dir_latch: got %b, expected 0101", parallel_out);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(4'b1100, 4'b1111, 1'b0, 1'b0);
    send_word(4'b0011, 4'b1111, 1'b0, 1'b0);
    total++;
    if (parallel_out !== 4'b1100 || out_valid !== 1'b1 || serial_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold: got pout=%b ov=%b rdy=%b, expected 1100 1 0", parallel_out, out_valid, serial_ready);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (parallel_out !== 4'b0011 || out_valid !== 1'b1 || serial_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got pout=%b ov=%b rdy=%b, expected 0011 1 1", parallel_out, out_valid, serial_ready);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || parallel_out !== 4'b0011) begin
      bad++;
      $display("FAIL drain_clear: got pout=%b ov=%b, expected 0011 0", parallel_out, out_valid);
    end
  endtask

  task automatic test_enable();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      total++;
      if (serial_ready !== 1'b0) begin
        bad++;
        $display("FAIL enable_gate: got serial_ready=%b, expected 0", serial_ready);
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`endif
    total++;
    if (parallel_out !== 4'b1101 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL enable_resume: got %b ov=%b, expected 1101 1", parallel_out, out_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    send_word(4'b1111, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    total++;
    if (out_valid !== 1'b0 || parallel_out !== '0) begin
      bad++;
      $display("FAIL reset_mid: got pout=%b ov=%b, expected 0000 0", parallel_out, out_valid);
    end
    send_word(4'b0110, 4'b1111, 1'b1, 1'b0);
    total++;
    if (parallel_out !== 4'b0110 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL after_reset: got %b ov=%b, expected 0110 1", parallel_out, out_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    for (int k = 0; k < 3; k++) begin
      w = WIDTH'($urandom);
      for (int i = WIDTH-1; i >= 0; i--) begin
        enable = 1'b1; #0;
        total++;
        if (serial_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready: got serial_ready=%b, expected 1 (word %0d bit %0d)", serial_ready, k, i);
        end
        step(1'b1, 1'b1, w[i], 1'b1, 1'b1);
      end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
      step(1'b1, 1'b1, ^w, 1'b1, 1'b1);
`endif
      total++;
      if (parallel_out !== w || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_word: got %b ov=%b, expected %b 1", parallel_out, out_valid, w);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_parity();
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    send_word(4'b1011, 4'b1111, 1'b1, 1'b0);
    total++;
    if (parity_err !== 1'b0 || parallel_out !== 4'b1011) begin
      bad++;
      $display("FAIL parity_ok: got perr=%b pout=%b, expected 0 1011", parity_err, parallel_out);
    end
    send_word(4'b1011, 4'b1111, 1'b1, 1'b1);
    total++;
    if (parity_err !== 1'b1) begin
      bad++;
      $display("FAIL parity_bad: got perr=%b, expected 1", parity_err);
    end
`else
    send_word(4'b1011, 4'b1111, 1'b1, 1'b1);
    total++;
    if (parity_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_off: got perr=%b, expected 0", parity_err);
    end
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 80, $urandom_range(99) < 70, 1'($urandom), 1'($urandom),
           $urandom_range(99) < 50);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (exp_w.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL random_drain: got %0d words pending, ov=%b, expected 0 and 0", exp_w.size(), out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dir = 1'b0; serial_in = 1'b0; serial_valid = 1'b0; out_ready = 1'b0;
    model_clear();
    @(negedge clock);
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
